// File: rtl/game_ctrl.sv
// Game controller: button sync, frame tick, collision/score FSM and final pixel composition.
// Sits between the sprite/ground renderers and the VGA output.
module game_ctrl #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned SCORE_DIV = 6,
    parameter int unsigned SCORE_MAX = 9999
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [8:0]  i_row_addr,
    input  logic [9:0]  i_col_addr,
    input  logic        i_btn_start,
    input  logic        i_ground_px,
    input  logic        i_dino_px,
    input  logic        i_obst_px,
    output logic        o_game_status,
    output logic        o_fresh,
    output logic        o_hit,
    output logic [13:0] o_score,
    output logic [13:0] o_hi_score,
    output logic [11:0] o_rgb
);

    localparam int unsigned    CNT_W     = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCORE_DIV - 1);
    localparam logic [13:0]    SCORE_TOP = 14'(SCORE_MAX);
    localparam logic [8:0]     ROW_LIM   = 9'(V_ACTIVE);
    localparam logic [9:0]     COL_LIM   = 10'(H_ACTIVE);

    typedef enum logic [1:0] {StIdle, StRun, StOver} state_t;

    state_t             r_state, w_state_next;
    logic               r_sync1, r_sync2, r_sync3, r_start;
    logic               r_fresh, r_fresh_prev;
    logic [CNT_W-1:0]   r_frame_cnt, w_frame_cnt_next;
    logic [13:0]        r_score, w_score_next;
    logic [13:0]        r_hi_score, w_hi_score_next;
    logic               r_hit_flag, w_hit_flag_next;
    logic               r_hit, w_hit_next;
    logic [11:0]        r_rgb, w_rgb_next;
    logic               w_frame_end, w_active, w_collide;

    assign w_frame_end = r_fresh & ~r_fresh_prev;
    assign w_active    = (i_row_addr < ROW_LIM) && (i_col_addr < COL_LIM);
    assign w_collide   = w_active & i_dino_px & i_obst_px;

    always_comb begin
        w_state_next     = r_state;
        w_frame_cnt_next = r_frame_cnt;
        w_score_next     = r_score;
        w_hi_score_next  = r_hi_score;
        w_hit_flag_next  = r_hit_flag;
        w_hit_next       = 1'b0;
        unique case (r_state)
            StIdle, StOver: begin
                if (r_start) begin
                    w_state_next     = StRun;
                    w_frame_cnt_next = '0;
                    w_score_next     = '0;
                    w_hit_flag_next  = 1'b0;
                end
            end
            StRun: begin
                // A collision seen this frame wins over the score tick at the boundary.
                if (w_frame_end) begin
                    w_hit_flag_next = 1'b0;
                    if (r_hit_flag) begin
                        w_state_next = StOver;
                        w_hit_next   = 1'b1;
                        if (r_score > r_hi_score) begin
                            w_hi_score_next = r_score;
                        end
                    end else if (r_frame_cnt == CNT_LAST) begin
                        w_frame_cnt_next = '0;
                        if (r_score < SCORE_TOP) begin
                            w_score_next = r_score + 14'd1;
                        end
                    end else begin
                        w_frame_cnt_next = r_frame_cnt + 1'b1;
                    end
                end else if (w_collide) begin
                    w_hit_flag_next = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_rgb_next = 12'hFFF;
        if (!w_active) begin
            w_rgb_next = 12'h000;
        end else if (i_dino_px) begin
            w_rgb_next = (r_state == StOver) ? 12'hF00 : 12'h333;
        end else if (i_obst_px && (r_state != StIdle)) begin
            w_rgb_next = 12'h070;
        end else if (i_ground_px) begin
            w_rgb_next = 12'h555;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync3      <= 1'b0;
            r_start      <= 1'b0;
            r_fresh      <= 1'b0;
            r_fresh_prev <= 1'b0;
            r_frame_cnt  <= '0;
            r_score      <= '0;
            r_hi_score   <= '0;
            r_hit_flag   <= 1'b0;
            r_hit        <= 1'b0;
            r_rgb        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_sync1      <= i_btn_start;
            r_sync2      <= r_sync1;
            r_sync3      <= r_sync2;
            r_start      <= r_sync2 & ~r_sync3;
            r_fresh      <= (i_row_addr >= ROW_LIM);
            r_fresh_prev <= r_fresh;
            r_frame_cnt  <= w_frame_cnt_next;
            r_score      <= w_score_next;
            r_hi_score   <= w_hi_score_next;
            r_hit_flag   <= w_hit_flag_next;
            r_hit        <= w_hit_next;
            r_rgb        <= w_rgb_next;
        end
    end

    assign o_game_status = (r_state == StRun);
    assign o_fresh       = r_fresh;
    assign o_hit         = r_hit;
    assign o_score       = r_score;
    assign o_hi_score    = r_hi_score;
    assign o_rgb         = r_rgb;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: per-cycle reference model of the game rules plus directed literal checks.
module tb_game_ctrl;

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_OVER = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        btn, ground, dino, obst;
    logic        status, fresh, hit;
    logic [13:0] score, hi_score;
    logic [11:0] rgb;
    logic        sat_status, sat_fresh, sat_hit;
    logic [13:0] sat_score, sat_hi_score;
    logic [11:0] sat_rgb;

    int n_cmp = 0;
    int n_bad = 0;
    int hit_count = 0;

    game_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_row_addr(row), .i_col_addr(col), .i_btn_start(btn),
        .i_ground_px(ground), .i_dino_px(dino), .i_obst_px(obst),
        .o_game_status(status), .o_fresh(fresh), .o_hit(hit), .o_score(score),
        .o_hi_score(hi_score), .o_rgb(rgb)
    );

    // One score per frame so saturation at the default maximum is reachable quickly.
    game_ctrl #(.SCORE_DIV(1)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_row_addr(row), .i_col_addr(col), .i_btn_start(btn),
        .i_ground_px(ground), .i_dino_px(dino), .i_obst_px(obst),
        .o_game_status(sat_status), .o_fresh(sat_fresh), .o_hit(sat_hit), .o_score(sat_score),
        .o_hi_score(sat_hi_score), .o_rgb(sat_rgb)
    );

    always #5 clk = ~clk;

    // Reference model: score is derived from the count of clean frames since the last start.
    int          m_phase, m_frames, m_hi;
    logic        m_flag, m_hit, m_fresh, m_fresh_prev;
    logic [3:0]  m_btn;
    logic [11:0] m_rgb;
    logic        m_start, m_frame_end;

    function automatic int score_of(input int frames);
        int s;
        s = frames / 6;
        return (s > 9999) ? 9999 : s;
    endfunction

    function automatic logic in_view(input logic [8:0] r, input logic [9:0] c);
        return (r < 9'd480) && (c < 10'd640);
    endfunction

    function automatic logic [11:0] expect_rgb(input int ph, input logic [8:0] r,
                                               input logic [9:0] c, input logic d,
                                               input logic o, input logic g);
        if (!in_view(r, c))                 return 12'h000;
        if (d)                              return (ph == PH_OVER) ? 12'hF00 : 12'h333;
        if (o && ph != PH_IDLE)             return 12'h070;
        if (g)                              return 12'h555;
        return 12'hFFF;
    endfunction

    // Button effect lands 3 edges after the pin is sampled; frame ends when blank level rises.
    assign m_start     = m_btn[2] & ~m_btn[3];
    assign m_frame_end = m_fresh & ~m_fresh_prev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= PH_IDLE; m_frames <= 0; m_hi <= 0; m_flag <= 1'b0; m_hit <= 1'b0;
            m_fresh <= 1'b0; m_fresh_prev <= 1'b0; m_btn <= 4'b0; m_rgb <= 12'h000;
        end else begin
            m_btn        <= {m_btn[2:0], btn};
            m_fresh      <= (row >= 9'd480);
            m_fresh_prev <= m_fresh;
            m_hit        <= 1'b0;
            m_rgb        <= expect_rgb(m_phase, row, col, dino, obst, ground);
            if (m_phase == PH_RUN) begin
                if (m_frame_end) begin
                    m_flag <= 1'b0;
                    if (m_flag) begin
                        m_phase <= PH_OVER;
                        m_hit   <= 1'b1;
                        if (score_of(m_frames) > m_hi) m_hi <= score_of(m_frames);
                    end else begin
                        m_frames <= m_frames + 1;
                    end
                end else if (in_view(row, col) && dino && obst) begin
                    m_flag <= 1'b1;
                end
            end else if (m_start) begin
                m_phase  <= PH_RUN;
                m_frames <= 0;
                m_flag   <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("game_status", status, m_phase == PH_RUN);
        check("fresh", fresh, m_fresh);
        check("hit", hit, m_hit);
        check("score", score, score_of(m_frames));
        check("hi_score", hi_score, m_hi);
        check("rgb", rgb, m_rgb);
        if (hit) hit_count++;
    end

    task automatic cyc(input int r, input int c, input logic b, input logic d,
                       input logic o, input logic g);
        row = 9'(r); col = 10'(c); btn = b; dino = d; obst = o; ground = g;
        @(negedge clk);
    endtask

    // Compressed frame: 4 visible rows, 2 blanking rows, 6 columns each.
    task automatic frame(input int crow, input int ccol);
        int   rows [6];
        int   cols [6];
        logic d, o, g;
        rows = '{0, 100, 200, 479, 480, 500};
        cols = '{0, 1, 320, 639, 640, 700};
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                g = (rows[r] == 479);
                d = (cols[c] == 320) && (rows[r] == 200 || rows[r] == 479);
                o = (cols[c] == 639) && (rows[r] == 0 || rows[r] == 479);
                o = o || (rows[r] == 200 && cols[c] == 1);
                if (rows[r] == crow && cols[c] == ccol) begin
                    d = 1'b1;
                    o = 1'b1;
                end
                cyc(rows[r], cols[c], 1'b0, d, o, g);
            end
        end
    endtask

    task automatic press();
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
            check("start_latency", status, k >= 4);
        end
        repeat (3) cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; row = '0; col = '0; btn = 1'b0; ground = 1'b0; dino = 1'b0; obst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_status", status, 1'b0);
        check("rst_score", score, 14'd0);
        check("rst_hi", hi_score, 14'd0);
        check("rst_rgb", rgb, 12'h000);
        check("rst_fresh", fresh, 1'b0);
        rst = 1'b0;

        frame(-1, -1);
        frame(-1, -1);
        cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_bg", rgb, 12'hFFF);
        cyc(0, 10, 1'b0, 1'b0, 1'b1, 1'b0);
        check("idle_no_obst", rgb, 12'hFFF);
        cyc(0, 700, 1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_hblank", rgb, 12'h000);
        cyc(500, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("vblank_rgb", rgb, 12'h000);
        check("vblank_fresh", fresh, 1'b1);
        cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("active_fresh", fresh, 1'b0);

        press();
        repeat (60) frame(-1, -1);
        check("score_60", score, 14'd10);
        check("hi_60", hi_score, 14'd0);
        check("sat_score_60", sat_score, 14'd60);

        frame(100, 700);
        check("blank_coll_run", status, 1'b1);

        frame(100, 0);
        check("coll_over", status, 1'b0);
        check("coll_hits", hit_count, 1);
        check("coll_hi", hi_score, 14'd10);
        check("coll_score", score, 14'd10);
        check("sat_coll_hi", sat_hi_score, 14'd61);
        cyc(100, 5, 1'b0, 1'b1, 1'b0, 1'b0);
        check("over_dino", rgb, 12'hF00);

        press();
        check("restart_score", score, 14'd0);
        check("restart_hi", hi_score, 14'd10);

        repeat (10005) begin
            cyc(480, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("sat_max", sat_score, 14'd9999);
        check("sat_running", sat_status, 1'b1);
        check("long_score", score, 14'd1667);

        #2 rst = 1'b1;
        #1;
        check("async_status", status, 1'b0);
        check("async_score", score, 14'd0);
        check("async_hi", hi_score, 14'd0);
        check("async_rgb", rgb, 12'h000);
        check("async_sat_score", sat_score, 14'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Sits directly downstream of the ground renderer and alongside the dino and obstacle sprite blocks.
- Consumes their 1-bit pixel streams and composes the 12-bit RGB pixel sent to the VGA output.
- Detects dino/obstacle collisions and runs the game state machine.
- Generates the game_status and fresh (frame tick) signals that the ground, dino and obstacle blocks consume, plus score and high-score counters.

Parameters:
- H_ACTIVE, 640, visible columns; col_addr >= H_ACTIVE is blanking.
- V_ACTIVE, 480, visible rows; row_addr >= V_ACTIVE is blanking.
- SCORE_DIV, 6, frames per score increment while running.
- SCORE_MAX, 9999, score saturation value.

Ports:
- clk, input, 1, pixel-domain clock.
- rst, input, 1, asynchronous active-high reset.
- row_addr, input, 9, current VGA row from the timing generator.
- col_addr, input, 10, current VGA column from the timing generator.
- btn_start, input, 1, raw start/jump button, asynchronous to clk.
- ground_px, input, 1, ground pixel from the ground renderer.
- dino_px, input, 1, dino sprite pixel.
- obst_px, input, 1, obstacle pixel.
- game_status, output, 1, 1 = running, 0 = idle or game over.
- fresh, output, 1, registered vertical-blank level; its falling edge marks the start of a frame.
- hit, output, 1, one-cycle pulse on a RUN->OVER transition.
- score, output, 14, current score in binary.
- hi_score, output, 14, best score since reset.
- rgb, output, 12, {r[3:0], g[3:0], b[3:0]} composed pixel.

Behaviour:
- Reset is asynchronous and active-high, using one clock. Reset values: state = IDLE, game_status = 0, fresh = 0, hit = 0, score = 0, hi_score = 0, rgb = 0; internal frame counter, hit flag and synchronizer all 0.
- btn_start: two-flop synchronizer, then rising-edge detect producing start_pulse (one cycle). Latency from the pin is 3 cycles.
- fresh: registered (row_addr >= V_ACTIVE), 1 cycle latency, glitch-free.
- Frame boundary is defined as the cycle in which fresh is registered 1 while it was 0 in the previous cycle (frame_end).
- FSM states: IDLE, RUN, OVER. game_status = 1 only in RUN.
  - IDLE -> RUN on start_pulse; score and frame counter cleared.
  - RUN -> OVER on frame_end when the hit flag is set. hit pulses for 1 cycle. hi_score <= max(hi_score, score). Hit flag cleared.
  - OVER -> RUN on start_pulse; score, frame counter and hit flag cleared. hi_score is kept.
  - start_pulse in RUN is ignored by this block; it is jump input for the dino block.
- Collision: in RUN, when row_addr < V_ACTIVE and col_addr < H_ACTIVE and dino_px & obst_px, set the sticky hit flag.
  - The flag is evaluated only at frame_end, then cleared at frame_end when no transition occurs.
  - ground_px never causes a collision.
  - Collision inputs outside RUN are ignored.
- Score: on each frame_end in RUN (without a collision transition), frame counter increments.
  - When the counter reaches SCORE_DIV-1 it wraps to 0 and score increments.
  - Score saturates at SCORE_MAX; it does not wrap.
- Simultaneous events: a collision at frame_end takes priority over the score increment; the score is frozen at its pre-frame value.
- rgb is registered with 1 cycle latency relative to row_addr/col_addr/px inputs.
  - Blanking (either coordinate out of the active area): 12'h000.
  - Priority in the active area: dino_px -> 12'h333 (12'hF00 in OVER); else obst_px -> 12'h070; else ground_px -> 12'h555; else background 12'hFFF.
  - In IDLE, obstacles are not drawn (obst_px ignored).
- rst asserted mid-game returns immediately to IDLE with all counters 0, including hi_score.

Test Plan:
- Assert rst, release, run 2 frames with all px = 0 -> state IDLE, game_status 0, score 0, rgb 12'hFFF in the active area and 12'h000 in blanking; fresh high only for rows 480+.
- Pulse btn_start for 5 cycles in IDLE -> game_status = 1 exactly 4 cycles after the press edge; holding the button does not retrigger.
- RUN for 60 frames with no collision, SCORE_DIV = 6 -> score = 10 and hi_score = 0.
- In RUN, drive dino_px = obst_px = 1 for one active pixel at row 100 -> game_status drops at the next frame_end, hit pulses 1 cycle, hi_score = score, and dino drawn 12'hF00.
- Drive dino_px & obst_px only at col 700 (blanking) -> no collision, game continues.
- Preload score to 9999 via a long run or force -> score stays 9999; start from OVER -> score 0, hi_score retained; rst mid-RUN -> all outputs return to reset values asynchronously.
